// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - perceptron predictor training engine
// Captures one resolved-branch request, then writes saturated weight rows one table per cycle.
module perceptron_trainer #(
  parameter int NUM_TABLES                   = 4,
  parameter int PERCEPTRON_TABLE_NUM_ENTRIES = 256,
  parameter int PERCEPTRON_NUM_WEIGHTS       = 8,
  parameter int PERCEPTRON_WEIGHT_WIDTH      = 8,
  parameter int BIAS_TABLE_NUM_ENTRIES       = 256,
  parameter int BIAS_WEIGHT_WIDTH            = 8,
  parameter int SUM_WIDTH                    = 16,
  parameter int THETA                        = 75,
  localparam int AW  = $clog2(PERCEPTRON_TABLE_NUM_ENTRIES),
  localparam int BAW = $clog2(BIAS_TABLE_NUM_ENTRIES),
  localparam int TW  = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
  localparam int NW  = PERCEPTRON_NUM_WEIGHTS,
  localparam int WW  = PERCEPTRON_WEIGHT_WIDTH,
  localparam int RW  = PERCEPTRON_NUM_WEIGHTS * PERCEPTRON_WEIGHT_WIDTH,
  localparam int BW  = BIAS_WEIGHT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        train_valid,
  output logic                        train_ready,
  input  logic                        train_taken,
  input  logic signed [SUM_WIDTH-1:0] train_sum,
  input  logic [NUM_TABLES*AW-1:0]    train_addrs,
  input  logic [NUM_TABLES*RW-1:0]    train_weights,
  input  logic [NUM_TABLES*NW-1:0]    train_hist,
  input  logic [BAW-1:0]              train_bias_addr,
  input  logic [BW-1:0]               train_bias,
  output logic                        write_enable,
  output logic [TW-1:0]               write_table_idx,
  output logic [AW-1:0]               write_addr,
  output logic [RW-1:0]               write_data,
  output logic                        bias_write_enable,
  output logic [BAW-1:0]              bias_write_addr,
  output logic [BW-1:0]               bias_write_data,
  output logic                        train_done,
  output logic                        trained
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                  state;
  logic [TW-1:0]           idx;
  logic [TW-1:0]           nidx;
  logic                    cap_taken;
  logic [NUM_TABLES*AW-1:0] cap_addrs;
  logic [NUM_TABLES*RW-1:0] cap_weights;
  logic [NUM_TABLES*NW-1:0] cap_hist;

  logic signed [SUM_WIDTH:0] sum_ext;
  logic [SUM_WIDTH:0]        abs_sum;
  logic                      need;

  function automatic logic [WW-1:0] step_w(input logic [WW-1:0] w, input logic up);
    logic [WW-1:0] max_v;
    logic [WW-1:0] min_v;
    max_v = {1'b0, {(WW-1){1'b1}}};
    min_v = {1'b1, {(WW-1){1'b0}}};
    if (up) return (w == max_v) ? w : w + WW'(1);
    else    return (w == min_v) ? w : w - WW'(1);
  endfunction

  function automatic logic [BW-1:0] step_b(input logic [BW-1:0] b, input logic up);
    logic [BW-1:0] max_v;
    logic [BW-1:0] min_v;
    max_v = {1'b0, {(BW-1){1'b1}}};
    min_v = {1'b1, {(BW-1){1'b0}}};
    if (up) return (b == max_v) ? b : b + BW'(1);
    else    return (b == min_v) ? b : b - BW'(1);
  endfunction

  // Each lane moves toward agreement between its history bit and the outcome.
  function automatic logic [RW-1:0] update_row(input logic [RW-1:0] row,
                                               input logic [NW-1:0] hist,
                                               input logic          taken);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < NW; j++)
      r[j*WW +: WW] = step_w(row[j*WW +: WW], hist[j] == taken);
    return r;
  endfunction

  // One extra bit keeps the magnitude of the most negative sum out of the threshold window.
  assign sum_ext = {train_sum[SUM_WIDTH-1], train_sum};
  assign abs_sum = sum_ext[SUM_WIDTH] ? -sum_ext : sum_ext;
  assign need    = (~train_sum[SUM_WIDTH-1] != train_taken) ||
                   (abs_sum <= (SUM_WIDTH+1)'(THETA));
  assign nidx    = idx + TW'(1);

  assign write_table_idx = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      idx               <= '0;
      cap_taken         <= 1'b0;
      cap_addrs         <= '0;
      cap_weights       <= '0;
      cap_hist          <= '0;
      train_ready       <= 1'b0;
      write_enable      <= 1'b0;
      write_addr        <= '0;
      write_data        <= '0;
      bias_write_enable <= 1'b0;
      bias_write_addr   <= '0;
      bias_write_data   <= '0;
      train_done        <= 1'b0;
      trained           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          train_done        <= 1'b0;
          trained           <= 1'b0;
          write_enable      <= 1'b0;
          bias_write_enable <= 1'b0;
          if (train_valid && train_ready) begin
            cap_taken   <= train_taken;
            cap_addrs   <= train_addrs;
            cap_weights <= train_weights;
            cap_hist    <= train_hist;
            train_ready <= 1'b0;
            if (need) begin
              // Table 0 and the bias go out in the first cycle straight from the request.
              state             <= WRITE;
              idx               <= '0;
              write_enable      <= 1'b1;
              write_addr        <= train_addrs[AW-1:0];
              write_data        <= update_row(train_weights[RW-1:0], train_hist[NW-1:0], train_taken);
              bias_write_enable <= 1'b1;
              bias_write_addr   <= train_bias_addr;
              bias_write_data   <= step_b(train_bias, train_taken);
            end else begin
              state      <= DONE;
              train_done <= 1'b1;
              trained    <= 1'b0;
            end
          end else begin
            train_ready <= 1'b1;
          end
        end
        WRITE: begin
          bias_write_enable <= 1'b0;
          if (idx == TW'(NUM_TABLES - 1)) begin
            state        <= DONE;
            write_enable <= 1'b0;
            train_done   <= 1'b1;
            trained      <= 1'b1;
          end else begin
            idx          <= nidx;
            write_enable <= 1'b1;
            write_addr   <= cap_addrs[int'(nidx)*AW +: AW];
            write_data   <= update_row(cap_weights[int'(nidx)*RW +: RW],
                                       cap_hist[int'(nidx)*NW +: NW], cap_taken);
          end
        end
        DONE: begin
          state       <= IDLE;
          train_done  <= 1'b0;
          trained     <= 1'b0;
          train_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - self-checking bench for perceptron_trainer
// Scoreboard queues hold expected writes/completions; a negedge monitor pops and compares them.
module tb_perceptron_trainer;

  logic         clk = 1'b0;
  logic         rst;
  logic         train_valid;
  logic         train_ready;
  logic         train_taken;
  logic [15:0]  train_sum;
  logic [31:0]  train_addrs;
  logic [255:0] train_weights;
  logic [31:0]  train_hist;
  logic [7:0]   train_bias_addr;
  logic [7:0]   train_bias;
  logic         write_enable;
  logic [1:0]   write_table_idx;
  logic [7:0]   write_addr;
  logic [63:0]  write_data;
  logic         bias_write_enable;
  logic [7:0]   bias_write_addr;
  logic [7:0]   bias_write_data;
  logic         train_done;
  logic         trained;

  perceptron_trainer dut (
    .clk(clk), .rst(rst),
    .train_valid(train_valid), .train_ready(train_ready),
    .train_taken(train_taken), .train_sum(train_sum),
    .train_addrs(train_addrs), .train_weights(train_weights),
    .train_hist(train_hist), .train_bias_addr(train_bias_addr),
    .train_bias(train_bias),
    .write_enable(write_enable), .write_table_idx(write_table_idx),
    .write_addr(write_addr), .write_data(write_data),
    .bias_write_enable(bias_write_enable), .bias_write_addr(bias_write_addr),
    .bias_write_data(bias_write_data),
    .train_done(train_done), .trained(trained)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [1:0] tbl; logic [7:0] addr; logic [63:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] addr; logic [7:0] data; } bias_t;
  typedef struct { int cyc; logic trn; } done_t;

  wr_t   wr_q[$];
  bias_t bias_q[$];
  done_t done_q[$];
  wr_t   we;
  bias_t be;
  done_t de;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int base;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_step(input logic [7:0] w, input bit up);
    int v;
    v = $signed(w);
    if (up) v = (v < 127) ? v + 1 : 127;
    else    v = (v > -128) ? v - 1 : -128;
    return v[7:0];
  endfunction

  function automatic logic [63:0] m_row(input logic [63:0] row, input logic [7:0] h, input bit tk);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = m_step(row[j*8 +: 8], h[j] == tk);
    return r;
  endfunction

  function automatic logic [127:0] all_outs();
    return {train_ready, write_enable, write_table_idx, write_addr, write_data,
            bias_write_enable, bias_write_addr, bias_write_data, train_done, trained};
  endfunction

  // Monitor: every strobe must match the head of its queue, including the cycle it appears in.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (write_enable) begin
        checks++;
        assert (wr_q.size() > 0) else begin
          errors++;
          $error("FAIL wr_unexpected obs=write tbl %0d exp=none", write_table_idx);
        end
        if (wr_q.size() > 0) begin
          we = wr_q.pop_front();
          check("wr_cyc", cyc, we.cyc);
          check("wr_tbl", write_table_idx, we.tbl);
          check("wr_addr", write_addr, we.addr);
          check("wr_data", write_data, we.data);
        end
      end
      if (bias_write_enable) begin
        checks++;
        assert (bias_q.size() > 0) else begin
          errors++;
          $error("FAIL bias_unexpected obs=bias write exp=none");
        end
        if (bias_q.size() > 0) begin
          be = bias_q.pop_front();
          check("bias_cyc", cyc, be.cyc);
          check("bias_addr", bias_write_addr, be.addr);
          check("bias_data", bias_write_data, be.data);
        end
      end
      if (train_done) begin
        checks++;
        assert (done_q.size() > 0) else begin
          errors++;
          $error("FAIL done_unexpected obs=done exp=none");
        end
        if (done_q.size() > 0) begin
          de = done_q.pop_front();
          check("done_cyc", cyc, de.cyc);
          check("trained", trained, de.trn);
        end
      end
    end
  end

  // Called right after a negedge with train_ready high; returns at the negedge of cycle 1.
  task automatic send(input bit tk, input int sum, input bit hold);
    int a;
    bit need;
    train_taken = tk;
    train_sum   = sum[15:0];
    train_valid = 1'b1;
    base = cyc;
    a = (sum < 0) ? -sum : sum;
    need = ((sum >= 0) != tk) || (a <= 75);
    if (need) begin
      for (int t = 0; t < 4; t++)
        wr_q.push_back('{base + 1 + t, t[1:0], train_addrs[t*8 +: 8],
                         m_row(train_weights[t*64 +: 64], train_hist[t*8 +: 8], tk)});
      bias_q.push_back('{base + 1, train_bias_addr, m_step(train_bias, tk)});
      done_q.push_back('{base + 5, 1'b1});
    end else begin
      done_q.push_back('{base + 1, 1'b0});
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) train_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int k);
    for (int i = 0; i < 40 && train_ready !== 1'b1; i++) @(negedge clk);
    check(tag, cyc - base, k);
  endtask

  task automatic rand_req();
    train_addrs     = $urandom;
    train_hist      = $urandom;
    train_bias_addr = 8'($urandom);
    train_bias      = 8'($urandom);
    for (int t = 0; t < 8; t++) train_weights[t*32 +: 32] = $urandom;
  endtask

  initial begin
    rst = 1'b0;
    train_valid = 1'b1;
    train_taken = 1'b1;
    train_sum = 16'hfff6;
    train_addrs = 32'h0f0b0703;
    train_weights = '0;
    train_hist = '1;
    train_bias_addr = 8'd5;
    train_bias = 8'd0;

    // Reset with a pending request: nothing may be captured or driven.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outs", all_outs(), '0);
    end
    rst = 1'b1;
    train_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", train_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("reset_no_capture", wr_q.size() + done_q.size(), 0);

    // Mispredict from zero weights.
    send(1'b1, -10, 1'b0);
    check("write_busy_ready", train_ready, 1'b0);
    wait_ready("mispredict_ready", 6);

    // Confident and correct: skip.
    send(1'b1, 200, 1'b0);
    wait_ready("skip_ready", 2);

    // Threshold edges.
    rand_req();
    send(1'b1, 75, 1'b0);
    wait_ready("theta_eq_ready", 6);
    rand_req();
    send(1'b1, 76, 1'b0);
    wait_ready("theta_over_ready", 2);
    train_weights = '0;
    train_bias = 8'd0;
    send(1'b0, 0, 1'b0);
    wait_ready("zero_sum_ready", 6);
    rand_req();
    send(1'b0, -75, 1'b0);
    wait_ready("neg_theta_ready", 6);
    rand_req();
    send(1'b0, -32768, 1'b0);
    wait_ready("min_sum_ready", 2);

    // Saturation and mixed lanes.
    rand_req();
    train_weights[63:0] = 64'h6403_0000_fd05_807f;
    train_weights[127:64] = {8{8'h7f}};
    train_weights[191:128] = {8{8'h80}};
    train_hist[7:0] = 8'b1010_1001;
    train_hist[15:8] = 8'hff;
    train_hist[23:16] = 8'h00;
    train_bias = 8'h7f;
    send(1'b1, -5, 1'b0);
    wait_ready("sat_up_ready", 6);
    rand_req();
    train_bias = 8'h80;
    train_weights[63:0] = {8{8'h80}};
    train_hist[7:0] = 8'hff;
    send(1'b0, 5, 1'b0);
    wait_ready("sat_down_ready", 6);

    // Busy request ignored, then reset mid-sequence.
    rand_req();
    send(1'b1, -20, 1'b1);
    rand_req();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("midreset_outs", all_outs(), '0);
    repeat (2) @(negedge clk);
    check("abandon_wr_left", wr_q.size(), 2);
    check("abandon_done_left", done_q.size(), 1);
    check("abandon_bias_left", bias_q.size(), 0);
    wr_q.delete();
    done_q.delete();
    rst = 1'b1;
    train_valid = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", train_ready, 1'b1);
    rand_req();
    send(1'b1, 30, 1'b0);
    wait_ready("post_reset_ready", 6);

    repeat (3) @(negedge clk);
    check("queues_drained", wr_q.size() + bias_q.size() + done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Training engine for the perceptron predictor: accepts one resolved-branch training request, decides whether training is needed, computes saturating weight updates and drives the perceptron weight table's sequential write port, one table per cycle, plus the bias write port. It sits between branch resolution and the weight table's write/bias-write ports.

## Interface
Parameters (defaults from `global_parameters`):
- NUM_TABLES, 4, number of perceptron tables
- PERCEPTRON_TABLE_NUM_ENTRIES, 256, entries per table
- PERCEPTRON_NUM_WEIGHTS, 8, weights per entry
- PERCEPTRON_WEIGHT_WIDTH, 8, signed two's-complement weight width
- BIAS_TABLE_NUM_ENTRIES, 256, bias entries
- BIAS_WEIGHT_WIDTH, 8, signed bias width
- SUM_WIDTH, 16, signed perceptron output width
- THETA, 75, training threshold (unsigned, fits SUM_WIDTH-1 bits)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- train_valid  in  1  training request present
- train_ready  out  1  trainer can accept a request
- train_taken  in  1  resolved outcome (1 = taken)
- train_sum  in  SUM_WIDTH  signed perceptron output computed at prediction
- train_addrs  in  NUM_TABLES×clog2(PERCEPTRON_TABLE_NUM_ENTRIES)  per-table row index used at prediction
- train_weights  in  NUM_TABLES×PERCEPTRON_NUM_WEIGHTS×PERCEPTRON_WEIGHT_WIDTH  weight rows read at prediction
- train_hist  in  NUM_TABLES×PERCEPTRON_NUM_WEIGHTS  history bit per weight (1 = taken)
- train_bias_addr  in  clog2(BIAS_TABLE_NUM_ENTRIES)  bias index
- train_bias  in  BIAS_WEIGHT_WIDTH  bias read at prediction
- write_enable  out  1  table write strobe
- write_table_idx  out  clog2(NUM_TABLES)  table being written
- write_addr  out  clog2(PERCEPTRON_TABLE_NUM_ENTRIES)  row being written
- write_data  out  PERCEPTRON_NUM_WEIGHTS×PERCEPTRON_WEIGHT_WIDTH  updated row
- bias_write_enable  out  1  bias write strobe
- bias_write_addr  out  clog2(BIAS_TABLE_NUM_ENTRIES)  bias index
- bias_write_data  out  BIAS_WEIGHT_WIDTH  updated bias
- train_done  out  1  one-cycle completion pulse
- trained  out  1  valid with train_done: 1 = writes were issued

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE: train_ready=1. On train_valid&&train_ready, capture all train_* inputs into registers; predicted = (train_sum >= 0); need = (predicted != train_taken) || (|train_sum| <= THETA). need → WRITE with idx=0, else → DONE with trained=0.
- WRITE: write_enable=1, write_table_idx=idx, write_addr=captured addr[idx], write_data = update(captured weights[idx], hist[idx]). bias_write_enable=1 only when idx==0, with bias_write_addr/data from captured bias. idx increments each cycle; at idx==NUM_TABLES-1 → DONE with trained=1.
- DONE: train_done=1 for one cycle, train_ready=0, → IDLE.
- Update rule per weight: agree = (hist bit == train_taken); agree → w+1 saturating at +2^(W-1)-1, else w−1 saturating at −2^(W-1). Bias uses train_taken as its input (taken → +1, not-taken → −1), same saturation.
- |train_sum| computed at SUM_WIDTH+1 bits; −2^(SUM_WIDTH-1) never counts as ≤ THETA.
- Updates use captured weights only; no bypass of in-flight writes. Upstream must not issue a request whose read rows predate an incomplete training sequence to the same rows.
- train_valid while train_ready=0 is ignored; the request is not captured.

## Timing
- Request accepted at edge 0. Trained: writes in cycles 1..NUM_TABLES, train_done in cycle NUM_TABLES+1, train_ready=1 in cycle NUM_TABLES+2. Skipped: train_done in cycle 1, train_ready in cycle 2.
- Throughput: one request per NUM_TABLES+2 cycles (trained) or 2 cycles (skipped).
- All outputs derive from registers (state, idx, captured data); no combinational input-to-output path.
- Reset (rst=0, any time): state=IDLE, idx=0, train_ready=0 while asserted, 1 from the first cycle after deassertion; write_enable, bias_write_enable, train_done, trained, write_table_idx, write_addr, write_data, bias_write_addr, bias_write_data all 0 immediately. An interrupted sequence is abandoned; rows already written stay written.

## Test plan
- Reset: hold rst=0 for 3 cycles with train_valid=1 → all outputs 0; train_ready=1 in the first cycle after release; no request is captured during reset.
- Mispredict: taken=1, sum=−10, all weights and bias 0, all hist=1, addrs {3,7,11,15} → cycles 1–4 write tables 0..3 at rows 3,7,11,15 with every weight 0x01; bias 0x01 written in cycle 1 only; train_done=1, trained=1 in cycle 5.
- Confident correct: taken=1, sum=200 → no write strobes; train_done=1, trained=0 in cycle 1; train_ready=1 in cycle 2.
- Threshold edges: taken=1, sum=75 → trains; sum=76 → skips; sum=0, taken=0 → mispredict, trains with bias −1 (0xFF).
- Saturation: weights 127 with hist agreeing, −128 with hist disagreeing, bias 127 with taken=1 → written values stay 127, −128, 127; mixed row updates each lane independently.
- Reset mid-operation and busy: train_valid held high during WRITE is ignored; rst=0 asserted in cycle 2 → write_enable drops immediately, table 2 is never written, and the next request after release starts at table 0.
